// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, req/ack data-memory port, load extraction and stall.
// Optional misalignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluOutE,
  input  logic [31:0] writeDataE,
  input  logic [4:0]  writeRegE,
  input  logic        regWriteE,
  input  logic        memReadE,
  input  logic        memWriteE,
  input  logic [1:0]  memSizeE,
  input  logic        memSignedE,
  output logic [31:0] aluOutM,
  output logic [4:0]  writeRegM,
  output logic        regWriteM,
  output logic        memToRegM,
  output logic [31:0] readDataM,
  output logic        memStallM,
  output logic        busErrM,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWdata,
  output logic [3:0]  dmBe,
  input  logic [31:0] dmRdata,
  input  logic        dmAck
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ABORT} state_t;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic [31:0]      writeDataM;
  logic             regWriteR;
  logic             memWriteM;
  logic [1:0]       memSizeM;
  logic             memSignedM;
  logic [31:0]      rdata;
  logic             advance;
  logic             memOp;
  logic             done;
  logic             misaligned;
  logic [31:0]      laneWord;
  logic [7:0]       byteVal;
  logic [15:0]      halfVal;
  logic [31:0]      loadVal;

  assign advance   = ~memStallM;
  assign memOp     = memToRegM | memWriteM;
  assign done      = (state == DONE) || (state == ABORT);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memOp & (((memSizeM == 2'b01) & aluOutM[0]) |
                               (memSizeM[1] & (|aluOutM[1:0])));
`else
  assign misaligned = 1'b0;
`endif

  assign dmReq     = memOp & ~done & ~misaligned;
  assign memStallM = dmReq & ~dmAck;
  assign busErrM   = (state == ABORT) | misaligned;
  assign regWriteM = regWriteR & ~busErrM;
  assign dmAddr    = {aluOutM[31:2], 2'b00};
  assign dmWe      = memWriteM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluOutM    <= '0;
      writeDataM <= '0;
      writeRegM  <= '0;
      regWriteR  <= 1'b0;
      memToRegM  <= 1'b0;
      memWriteM  <= 1'b0;
      memSizeM   <= '0;
      memSignedM <= 1'b0;
    end else if (advance) begin
      aluOutM    <= aluOutE;
      writeDataM <= writeDataE;
      writeRegM  <= writeRegE;
      regWriteR  <= regWriteE;
      memToRegM  <= memReadE;
      memWriteM  <= memWriteE;
      memSizeM   <= memSizeE;
      memSignedM <= memSignedE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (dmReq && dmAck && memToRegM)
        rdata <= dmRdata;
    end
  end

  // A leaving instruction always restarts the FSM; the IDLE cycle counts as the first request cycle
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (advance) begin
      nextState = IDLE;
      nextCnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (dmReq && !dmAck) begin
            nextState = (WAIT_LIMIT == 1) ? ABORT : WAIT;
            nextCnt   = CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmAck)
            nextState = DONE;
          else if (cnt == LIMIT_M1)
            nextState = ABORT;
          nextCnt = cnt + CNT_W'(1);
        end
        default: nextState = state;
      endcase
    end
  end

  always_comb begin
    dmBe    = 4'b0000;
    dmWdata = 32'h0;
    if (memOp) begin
      case (memSizeM)
        2'b00: dmBe = 4'b0001 << aluOutM[1:0];
        2'b01: dmBe = aluOutM[1] ? 4'b1100 : 4'b0011;
        default: dmBe = 4'b1111;
      endcase
    end
    if (memWriteM) begin
      case (memSizeM)
        2'b00: dmWdata = {4{writeDataM[7:0]}};
        2'b01: dmWdata = {2{writeDataM[15:0]}};
        default: dmWdata = writeDataM;
      endcase
    end
  end

  // Ack cycle takes data straight from the bus; later cycles use the latched copy
  assign laneWord = (state == DONE) ? rdata : dmRdata;

  always_comb begin
    byteVal = laneWord[7:0];
    case (aluOutM[1:0])
      2'b00: byteVal = laneWord[7:0];
      2'b01: byteVal = laneWord[15:8];
      2'b10: byteVal = laneWord[23:16];
      default: byteVal = laneWord[31:24];
    endcase
    halfVal = aluOutM[1] ? laneWord[31:16] : laneWord[15:0];
    case (memSizeM)
      2'b00: loadVal = {{24{memSignedM & byteVal[7]}}, byteVal};
      2'b01: loadVal = {{16{memSignedM & halfVal[15]}}, halfVal};
      default: loadVal = laneWord;
    endcase
  end

  assign readDataM = memToRegM ? loadVal : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads/stores against a behavioural model.
module tb_mem_stage;

  localparam int WL = 4;

  logic        clk;
  logic        rst;
  logic [31:0] aluOutE;
  logic [31:0] writeDataE;
  logic [4:0]  writeRegE;
  logic        regWriteE;
  logic        memReadE;
  logic        memWriteE;
  logic [1:0]  memSizeE;
  logic        memSignedE;
  logic [31:0] aluOutM;
  logic [4:0]  writeRegM;
  logic        regWriteM;
  logic        memToRegM;
  logic [31:0] readDataM;
  logic        memStallM;
  logic        busErrM;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic [3:0]  dmBe;
  logic [31:0] dmRdata;
  logic        dmAck;

  int errors = 0;
  int checks = 0;

  mem_stage #(.WAIT_LIMIT(WL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .aluOutE(aluOutE), .writeDataE(writeDataE), .writeRegE(writeRegE),
    .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .memSizeE(memSizeE), .memSignedE(memSignedE),
    .aluOutM(aluOutM), .writeRegM(writeRegM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .readDataM(readDataM), .memStallM(memStallM),
    .busErrM(busErrM), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
    .dmWdata(dmWdata), .dmBe(dmBe), .dmRdata(dmRdata), .dmAck(dmAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] wreg, input logic rw);
    memReadE   = rd;
    memWriteE  = wr;
    memSizeE   = size;
    memSignedE = sgn;
    aluOutE    = addr;
    writeDataE = wdata;
    writeRegE  = wreg;
    regWriteE  = rw;
  endtask

  // Reference rules: lane choice, extension, byte enables and lane replication
  function automatic logic [1:0] effSize(input logic [1:0] size);
    return (size == 2'b11) ? 2'b10 : size;
  endfunction

  function automatic logic [31:0] expLoad(input logic [1:0] size, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] word);
    int sh;
    logic [31:0] v;
    if (effSize(size) == 2'b00) begin
      sh = 8 * addr[1:0];
      v = (word >> sh) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end else if (effSize(size) == 2'b01) begin
      sh = 16 * addr[1];
      v = (word >> sh) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] expBe(input logic [1:0] size, input logic [31:0] addr);
    if (effSize(size) == 2'b00) return 4'b0001 << addr[1:0];
    if (effSize(size) == 2'b01) return 4'b0011 << (2 * addr[1]);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] d);
    if (effSize(size) == 2'b00) return (d & 32'hFF) * 32'h01010101;
    if (effSize(size) == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    if (effSize(size) == 2'b01) return addr[0];
    if (effSize(size) == 2'b10) return addr[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one instruction through MEM. Entry/exit: just after a rising edge with a bubble in MEM.
  // lat = cycles before ack; lat >= WL means the memory never answers.
  task automatic runInstr(input string name, input logic rd, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] wreg, input logic rw, input int lat,
                          input logic [31:0] rdata);
    int k;
    bit fin;
    logic memOp, mis, ackNow, expReq, expStall, expErr, expRw;
    applyStimulus(rd, wr, size, sgn, addr, wdata, wreg, rw);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    memOp = rd | wr;
    mis = memOp && isMisaligned(size, addr);
    k = 0;
    fin = 0;
    while (!fin) begin
      ackNow = memOp && !mis && (lat < WL) && (k == lat);
      dmAck = ackNow;
      dmRdata = ackNow ? rdata : $urandom;
      if (!memOp || mis) begin
        expReq = 0; expStall = 0; expErr = mis; expRw = rw & ~mis; fin = 1;
      end else if (ackNow) begin
        expReq = 1; expStall = 0; expErr = 0; expRw = rw; fin = 1;
      end else if (k >= WL) begin
        expReq = 0; expStall = 0; expErr = 1; expRw = 0; fin = 1;
      end else begin
        expReq = 1; expStall = 1; expErr = 0; expRw = rw;
      end
      #3;
      checkOutput({name, ".dmReq"}, 32'(dmReq), 32'(expReq));
      checkOutput({name, ".stall"}, 32'(memStallM), 32'(expStall));
      checkOutput({name, ".busErr"}, 32'(busErrM), 32'(expErr));
      checkOutput({name, ".regWrite"}, 32'(regWriteM), 32'(expRw));
      checkOutput({name, ".aluOutM"}, aluOutM, addr);
      if (k == 0) begin
        checkOutput({name, ".writeRegM"}, 32'(writeRegM), 32'(wreg));
        checkOutput({name, ".memToRegM"}, 32'(memToRegM), 32'(rd));
      end
      if (expReq) begin
        checkOutput({name, ".dmAddr"}, dmAddr, {addr[31:2], 2'b00});
        checkOutput({name, ".dmWe"}, 32'(dmWe), 32'(wr));
        checkOutput({name, ".dmBe"}, 32'(dmBe), 32'(expBe(size, addr)));
        if (wr) checkOutput({name, ".dmWdata"}, dmWdata, expWdata(size, wdata));
      end
      if (ackNow && rd)
        checkOutput({name, ".readData"}, readDataM, expLoad(size, sgn, addr, rdata));
      @(posedge clk); #1;
      k++;
      if (!fin && k > WL + 1) begin
        checkOutput({name, ".cycleBudget"}, 32'(k), 32'(WL + 1));
        fin = 1;
      end
    end
    dmAck = 1'b0;
  endtask

  initial begin
    int op, lat;
    logic [31:0] a;
    rst = 1'b0;
    dmAck = 1'b0;
    dmRdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.dmReq", 32'(dmReq), 32'd0);
    checkOutput("reset.stall", 32'(memStallM), 32'd0);
    checkOutput("reset.aluOutM", aluOutM, 32'h0);
    checkOutput("reset.regWrite", 32'(regWriteM), 32'd0);
    checkOutput("reset.busErr", 32'(busErrM), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    runInstr("sw_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 0, 32'h0);
    runInstr("lb_signed", 1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 5'd7, 1'b1, 3, 32'h80FF1234);
    runInstr("lhu", 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 5'd8, 1'b1, 1, 32'h80FF1234);
    runInstr("lw_timeout", 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd9, 1'b1, 99, 32'h0);
    runInstr("alu_op", 1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd3, 1'b1, 0, 32'h0);

    // Reset while an access is waiting, then a stray ack right after reset
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd4, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rstwait.stallBefore", 32'(memStallM), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rstwait.dmReq", 32'(dmReq), 32'd0);
    checkOutput("rstwait.stall", 32'(memStallM), 32'd0);
    checkOutput("rstwait.aluOutM", aluOutM, 32'h0);
    checkOutput("rstwait.regWrite", 32'(regWriteM), 32'd0);
    checkOutput("rstwait.memToReg", 32'(memToRegM), 32'd0);
    checkOutput("rstwait.dmBe", 32'(dmBe), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    dmAck = 1'b1;
    dmRdata = 32'hCAFEF00D;
    #2;
    checkOutput("postrst.dmReq", 32'(dmReq), 32'd0);
    checkOutput("postrst.stall", 32'(memStallM), 32'd0);
    @(posedge clk); #1;
    dmAck = 1'b0;
    runInstr("lw_after_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 5'd5, 1'b1, 2, 32'h11223344);

    runInstr("lw_unaligned", 1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 5'd6, 1'b1, 0, 32'hA5A5A5A5);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      lat = $urandom_range(0, WL + 1);
      a = $urandom;
      runInstr("rand", op == 1 || op == 3, op == 2, 2'($urandom_range(0, 3)), 1'($urandom),
               a, $urandom, 5'($urandom), 1'($urandom), lat, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
